// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a time,
// hands instructions to decode, and kills stale responses on redirect (FETCH_PERF_EN adds counters).
module fetch_ctrl #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              mem_req_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] pc_nx;
    logic [AWIDTH-1:0] target;
    logic              load;
    logic              unused_lsb;

    assign target     = {redirect_pc_i[AWIDTH-1:2], 2'b00};
    assign unused_lsb = ^redirect_pc_i[1:0];
    assign mem_req_o  = (state == S_REQ) && !rst;
    assign mem_addr_o = pc;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        load     = 1'b0;
        unique case (state)
            S_REQ: begin
                if (redirect_i) begin
                    pc_nx = target;
                    if (mem_gnt_i) state_nx = S_DRAIN;
                end else if (mem_gnt_i) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_nx    = target;
                    state_nx = mem_rvalid_i ? S_REQ : S_DRAIN;
                end else if (mem_rvalid_i) begin
                    state_nx = S_OUT;
                    load     = 1'b1;
                end
            end
            S_DRAIN: begin
                // The stale response is swallowed; a redirect only retargets the PC.
                if (redirect_i) pc_nx = target;
                if (mem_rvalid_i) state_nx = S_REQ;
            end
            S_OUT: begin
                if (redirect_i) begin
                    pc_nx    = target;
                    state_nx = S_REQ;
                end else if (insn_ready_i) begin
                    pc_nx    = pc + AWIDTH'(4);
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= BASEADDR;
            insn_valid_o <= 1'b0;
            pc_o         <= BASEADDR;
            insn_o       <= '0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            insn_valid_o <= (state_nx == S_OUT);
            if (load) begin
                pc_o   <= pc;
                insn_o <= mem_rdata_i;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (state == S_OUT && insn_ready_i && !redirect_i)
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (state == S_OUT && !insn_ready_i)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: transaction-level model checked every cycle
// plus literal expectations at key points (FETCH_PERF_EN also checks counters).
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] insn;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .insn_valid_o  (insn_valid),
        .insn_ready_i  (insn_ready),
        .pc_o          (pc_out),
        .insn_o        (insn)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o   (fetch_cnt),
        .stall_cnt_o   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Transaction model: next fetch address, an outstanding request
    // (possibly killed by a redirect), and a held instruction for decode.
    logic        m_busy  = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_have  = 1'b0;
    logic [31:0] m_pc    = 32'h01000000;
    logic [31:0] m_ipc   = '0;
    logic [31:0] m_idata = '0;
    logic [31:0] m_fetch = '0;
    logic [31:0] m_stall = '0;

    always @(posedge clk or posedge rst) begin : model
        logic granted;
        logic resp;
        if (rst) begin
            m_busy  <= 1'b0;
            m_stale <= 1'b0;
            m_have  <= 1'b0;
            m_pc    <= 32'h01000000;
            m_fetch <= '0;
            m_stall <= '0;
        end else begin
            granted = !m_busy && !m_have && mem_gnt;
            resp    = m_busy && mem_rvalid;
            if (m_have && !insn_ready) m_stall <= m_stall + 1;
            if (m_have && insn_ready && !redirect) m_fetch <= m_fetch + 1;
            if (redirect) begin
                m_pc    <= {redirect_pc[31:2], 2'b00};
                m_have  <= 1'b0;
                m_busy  <= granted || (m_busy && !mem_rvalid);
                m_stale <= granted || (m_busy && !mem_rvalid);
            end else begin
                if (m_have && insn_ready) begin
                    m_have <= 1'b0;
                    m_pc   <= m_pc + 32'd4;
                end
                if (granted) begin
                    m_busy  <= 1'b1;
                    m_stale <= 1'b0;
                end
                if (resp) begin
                    m_busy  <= 1'b0;
                    m_stale <= 1'b0;
                    if (!m_stale) begin
                        m_have  <= 1'b1;
                        m_ipc   <= m_pc;
                        m_idata <= mem_rdata;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("req", {31'd0, mem_req}, {31'd0, !rst && !m_busy && !m_have});
        chk("addr", mem_addr, m_pc);
        chk("valid", {31'd0, insn_valid}, {31'd0, m_have});
        if (m_have) begin
            chk("pc_o", pc_out, m_ipc);
            chk("insn_o", insn, m_idata);
        end
`ifdef FETCH_PERF_EN
        chk("fetch_cnt", fetch_cnt, m_fetch);
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    end

    task automatic step(input logic rd, input logic [31:0] tgt,
                        input logic g, input logic rv,
                        input logic [31:0] rdat, input logic rdy);
        redirect    = rd;
        redirect_pc = tgt;
        mem_gnt     = g;
        mem_rvalid  = rv;
        mem_rdata   = rdat;
        insn_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] rdat, input int stalls);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, rdat, 1'b0);
        repeat (stalls) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, insn_valid}, 32'd0);
        chk("rst_pc_o", pc_out, 32'h01000000);
        chk("rst_insn", insn, 32'd0);
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h01000000);

        // basic fetch, gnt immediately, rvalid one cycle later
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h00000013, 1'b0);
        chk("t1_valid", {31'd0, insn_valid}, 32'd1);
        chk("t1_pc", pc_out, 32'h01000000);
        chk("t1_insn", insn, 32'h00000013);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("t1_next", mem_addr, 32'h01000004);

        // backpressure
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h00100093, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            chk("bp_req", {31'd0, mem_req}, 32'd0);
            chk("bp_valid", {31'd0, insn_valid}, 32'd1);
            chk("bp_pc", pc_out, 32'h01000004);
            chk("bp_insn", insn, 32'h00100093);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("bp_next", mem_addr, 32'h01000008);

        // redirect in WAIT, stale data dropped
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 32'h01000100, 1'b0, 1'b0, '0, 1'b0);
        idle();
        step(1'b0, '0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("drain_valid", {31'd0, insn_valid}, 32'd0);
        chk("drain_addr", mem_addr, 32'h01000100);
        fetch(32'h00200113, 0);

        // redirect in REQ without gnt, misaligned target
        step(1'b1, 32'h01000102, 1'b0, 1'b0, '0, 1'b0);
        chk("align_addr", mem_addr, 32'h01000100);

        // redirect with gnt in REQ, then redirect + rvalid in WAIT
        step(1'b1, 32'h01000200, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'hBADBAD00, 1'b0);
        chk("rg_addr", mem_addr, 32'h01000200);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 32'h01000300, 1'b0, 1'b1, 32'hBADBAD01, 1'b0);
        chk("rv_valid", {31'd0, insn_valid}, 32'd0);
        chk("rv_addr", mem_addr, 32'h01000300);

        // redirect while offering an instruction kills it
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h00300193, 1'b0);
        step(1'b1, 32'h01000400, 1'b0, 1'b0, '0, 1'b1);
        chk("kill_addr", mem_addr, 32'h01000400);

        // PC wrap
        step(1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h00000013, 1'b0);
        chk("wrap_pc", pc_out, 32'hFFFFFFFC);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        chk("wrap_addr", mem_addr, 32'h00000000);

        // reset during WAIT
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, insn_valid}, 32'd0);
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_addr", mem_addr, 32'h01000000);
        mem_gnt = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rel_req", {31'd0, mem_req}, 32'd1);
        chk("rel_addr", mem_addr, 32'h01000000);

        // four accepted instructions, two stall cycles
        fetch(32'h00000013, 0);
        fetch(32'h00000113, 2);
        fetch(32'h00000213, 0);
        fetch(32'h00000313, 0);
        chk("perf_addr", mem_addr, 32'h01000010);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", fetch_cnt, 32'd4);
        chk("perf_stall", stall_cnt, 32'd2);
`endif
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer for the instruction-fetch datapath. It owns the program counter and issues one instruction-memory request at a time using a req/gnt/rvalid handshake. It hands each fetched instruction and its PC to decode over a valid/ready interface. It accepts redirects (branch/jump targets) from later stages and discards any in-flight response that the redirect makes stale.

Parameters:
AWIDTH, 32, address/PC width
DWIDTH, 32, instruction width
BASEADDR, 32'h01000000, PC value after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
redirect_i  in  1  load a new PC; highest priority
redirect_pc_i  in  AWIDTH  redirect target
mem_req_o  out  1  memory request valid
mem_addr_o  out  AWIDTH  request address; always 4-byte aligned
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid; at most one per grant, arriving 1 or more cycles after gnt
mem_rdata_i  in  DWIDTH  read data
insn_valid_o  out  1  instruction available to decode
insn_ready_i  in  1  decode accepts the instruction
pc_o  out  AWIDTH  PC of insn_o
insn_o  out  DWIDTH  fetched instruction

Behaviour:
- Reset values (asynchronous): state=REQ, pc=BASEADDR, mem_req_o=0, mem_addr_o=BASEADDR, insn_valid_o=0, pc_o=BASEADDR, insn_o=0.
- mem_req_o is combinationally 1 only in state REQ while rst is low.
  - The first request is raised in the first cycle after rst deasserts.
- mem_addr_o equals the pc register.
- Redirect alignment: redirect_pc_i[1:0] are forced to 0 before loading the PC.
- PC increment: pc+4, modulo 2^AWIDTH (0xFFFFFFFC wraps to 0x00000000).
- States:
  - REQ: mem_req_o=1.
    - gnt & !redirect -> WAIT.
    - redirect & !gnt -> stay REQ; pc=target.
    - redirect & gnt -> DRAIN; pc=target.
  - WAIT: await mem_rvalid_i.
    - rvalid & !redirect -> OUT; latch insn_o=rdata, pc_o=pc, insn_valid_o=1 next cycle.
    - redirect & !rvalid -> DRAIN; pc=target.
    - redirect & rvalid -> REQ; data dropped, pc=target.
  - DRAIN: wait for the stale rvalid; its data is never presented.
    - rvalid -> REQ.
    - A further redirect in DRAIN updates pc and stays in DRAIN.
  - OUT: insn_valid_o=1; pc_o/insn_o held stable until the handshake completes.
    - ready & !redirect -> REQ; pc=pc+4; insn_valid_o=0.
    - redirect (any ready) -> REQ; pc=target; insn_valid_o=0.
- Ordering: an instruction offered in the same cycle as a redirect is treated as killed.
  - Decode must ignore valid&ready in a redirect cycle.
  - The controller does not increment the PC on that transfer.
- Latency:
  - Minimum 3 cycles per instruction (REQ, WAIT, OUT) with gnt=1 and rvalid one cycle after gnt.
  - insn_valid_o rises the cycle after rvalid.
- Backpressure: while OUT with insn_ready_i=0, no new request is issued and outputs stay constant.
- Reset mid-operation: returns immediately to the reset values.
  - Any response arriving after reset deasserts that was not requested post-reset is not expected; memory is reset together with this block.
- Only one request is ever outstanding.
- mem_rvalid_i in REQ or OUT is a protocol error and is ignored.

Optional Feature:
FETCH_PERF_EN
- Defined: adds ports fetch_cnt_o out 32 and stall_cnt_o out 32, both reset to 0, both wrap at 2^32.
  - fetch_cnt_o increments on each valid&ready&!redirect transfer.
  - stall_cnt_o increments each cycle in OUT with insn_ready_i=0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset deasserted, gnt=1 immediately, rvalid+rdata=0x00000013 one cycle later, ready=1 -> mem_addr_o=0x01000000, then insn_valid_o=1 with pc_o=0x01000000 and insn_o=0x00000013, then next mem_addr_o=0x01000004.
- ready=0 for 3 cycles in OUT -> mem_req_o=0 and pc_o/insn_o/insn_valid_o stable; on ready=1, next request to pc+4.
- Redirect to 0x01000100 while in WAIT, rvalid (rdata 0xDEADBEEF) 2 cycles later -> 0xDEADBEEF never presented; next mem_addr_o=0x01000100.
- Redirect to 0x01000102 in REQ without gnt -> mem_addr_o=0x01000100 the next cycle.
- Redirect to 0xFFFFFFFC, fetch and accept -> next mem_addr_o=0x00000000.
- Assert rst during WAIT -> insn_valid_o=0 and mem_req_o=0 immediately; after release, first request to 0x01000000.
- With FETCH_PERF_EN, 4 accepted instructions and 2 stall cycles -> fetch_cnt_o=4, stall_cnt_o=2.
